// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forwarding sequencer for the 5-stage RV32 core.
// A shadow scoreboard of the E, M and W stage destinations drives the E-stage
// forwarding selects. A small FSM (RUN, LDSTALL, HALTING, HALTED, STEP)
// produces the load-use stalls, the taken-branch flushes and the debug
// halt/single-step sequence.
// Optional build macro: HAZARD_PERF_CNT_EN adds the perf_stall/perf_flush counters.
module hazard_controller #(
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic        regwrite_d,
    input  logic        load_d,
    input  logic        pcsrc_e,
    input  logic        dbg_halt,
    input  logic        dbg_step,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  fwd_a_e,
    output logic [1:0]  fwd_b_e,
    output logic        halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LDSTALL = 3'd1,
        ST_HALTING = 3'd2,
        ST_HALTED  = 3'd3,
        ST_STEP    = 3'd4
    } state_t;

    // Full decode-stage tag captured into E.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } tag_t;

    tag_t             e_tag_r;
    // M and W only need the destination and write enable for forwarding.
    logic [4:0]       m_rd_r;
    logic             m_rw_r;
    logic [4:0]       w_rd_r;
    logic             w_rw_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             ld_use_s;
    logic             stall_f_s;
    logic             stall_d_s;
    logic             flush_d_s;
    logic             flush_e_s;

    // Forward select for one source: M beats W, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_rw,
        input logic [4:0] w_rd,
        input logic       w_rw
    );
        logic [1:0] sel;
        if (m_rw && (m_rd != 5'd0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_rw && (w_rd != 5'd0) && (w_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Shadow scoreboard: E/M/W always advance, E takes a bubble on flush_e.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_tag_r <= '0;
            m_rd_r  <= 5'd0;
            m_rw_r  <= 1'b0;
            w_rd_r  <= 5'd0;
            w_rw_r  <= 1'b0;
        end else begin
            if (flush_e_s) begin
                e_tag_r <= '0;
            end else begin
                e_tag_r <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                             regwrite: regwrite_d, load: load_d};
            end
            m_rd_r <= e_tag_r.rd;
            m_rw_r <= e_tag_r.regwrite;
            w_rd_r <= m_rd_r;
            w_rw_r <= m_rw_r;
        end
    end

    assign ld_use_s = e_tag_r.load && (e_tag_r.rd != 5'd0) &&
                      ((e_tag_r.rd == rs1_d) || (e_tag_r.rd == rs2_d));

    // Next state and stall/flush controls; priority is branch, load-use, debug.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (pcsrc_e) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                end else if (ld_use_s) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    cnt_nxt_s = CNT_W'(LOAD_LAT - 1);
                    if (LOAD_LAT > 1) begin
                        state_nxt_s = ST_LDSTALL;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (dbg_halt) begin
                    state_nxt_s = ST_HALTING;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LDSTALL: begin
                if (pcsrc_e) begin
                    flush_d_s   = 1'b1;
                    flush_e_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end else begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (cnt_r <= CNT_W'(1)) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end
                end
            end
            ST_HALTING: begin
                stall_f_s = 1'b1;
                flush_e_s = 1'b1;
                // A taken branch clears IF/ID instead of holding it, so the
                // decode register is never stalled and flushed together.
                if (pcsrc_e) begin
                    flush_d_s = 1'b1;
                end else begin
                    stall_d_s = 1'b1;
                end
                if (!dbg_halt) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end else if (cnt_r >= CNT_W'(DRAIN_CYC - 1)) begin
                    state_nxt_s = ST_HALTED;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_e_s = 1'b1;
                if (!dbg_halt) begin
                    state_nxt_s = ST_RUN;
                end else if (dbg_step) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_STEP: begin
                state_nxt_s = ST_HALTING;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // FSM state and shared stall/drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Controls are forced low while reset is asserted, independent of inputs.
    assign stall_f = rst & stall_f_s;
    assign stall_d = rst & stall_d_s;
    assign flush_d = rst & flush_d_s;
    assign flush_e = rst & flush_e_s;
    assign halted  = rst & (state_r == ST_HALTED);

    assign fwd_a_e = fwd_sel(e_tag_r.rs1, m_rd_r, m_rw_r, w_rd_r, w_rw_r);
    assign fwd_b_e = fwd_sel(e_tag_r.rs2, m_rd_r, m_rw_r, w_rd_r, w_rw_r);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Stall cycles outside HALTED and decode-flush cycles, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (stall_f_s && (state_r != ST_HALTED)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if (flush_d_s) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
        end
    end

    assign perf_stall = perf_stall_r;
    assign perf_flush = perf_flush_r;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed steps followed by random
// traffic, every cycle compared against a behavioural model of the pipeline.
module tb_hazard_controller;

    localparam int LAT = 2;
    localparam int DRN = 3;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        regwrite_d, load_d, pcsrc_e, dbg_halt, dbg_step;
    logic        stall_f, stall_d, flush_d, flush_e, halted;
    logic [1:0]  fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    hazard_controller #(.LOAD_LAT(LAT), .DRAIN_CYC(DRN)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d),
        .pcsrc_e(pcsrc_e), .dbg_halt(dbg_halt), .dbg_step(dbg_step),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: instructions occupying E/M/W plus the controller mode.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } ins_t;

    ins_t        pe, pm, pw;
    int          m_ld_rem;
    int          m_drain;
    bit          m_halted;
    bit          m_step;
    logic [31:0] m_pstall, m_pflush;

    logic        obs_sf, obs_sd, obs_fd, obs_fe, obs_halted;
    logic [1:0]  obs_fa, obs_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] s);
        if (pm.rw && pm.rd != 5'd0 && pm.rd == s) return 2'b10;
        if (pw.rw && pw.rd != 5'd0 && pw.rd == s) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        pe = '0; pm = '0; pw = '0;
        m_ld_rem = 0; m_drain = 0; m_halted = 0; m_step = 0;
        m_pstall = 32'd0; m_pflush = 32'd0;
    endtask

    // Compare the current cycle against the model, then move the model one cycle on.
    task automatic eval_and_check();
        logic esf, esd, efd, efe, eh, hz;
        logic [1:0] efa, efb;
        esf = 1'b0; esd = 1'b0; efd = 1'b0; efe = 1'b0; eh = 1'b0;
        efa = ref_fwd(pe.rs1);
        efb = ref_fwd(pe.rs2);
        hz  = pe.ld && pe.rd != 5'd0 && (pe.rd == rs1_d || pe.rd == rs2_d);
        if (m_ld_rem > 0) begin
            if (pcsrc_e) begin efd = 1'b1; efe = 1'b1; m_ld_rem = 0; end
            else begin esf = 1'b1; esd = 1'b1; efe = 1'b1; m_ld_rem = m_ld_rem - 1; end
        end else if (m_drain > 0) begin
            esf = 1'b1; efe = 1'b1;
            if (pcsrc_e) efd = 1'b1; else esd = 1'b1;
            if (!dbg_halt) m_drain = 0;
            else begin
                m_drain = m_drain - 1;
                if (m_drain == 0) m_halted = 1;
            end
        end else if (m_halted) begin
            esf = 1'b1; esd = 1'b1; efe = 1'b1; eh = 1'b1;
            if (!dbg_halt) m_halted = 0;
            else if (dbg_step) begin m_halted = 0; m_step = 1; end
        end else if (m_step) begin
            m_step = 0; m_drain = DRN;
        end else begin
            if (pcsrc_e) begin efd = 1'b1; efe = 1'b1; end
            else if (hz) begin esf = 1'b1; esd = 1'b1; efe = 1'b1; m_ld_rem = LAT - 1; end
            else if (dbg_halt) m_drain = DRN;
        end
        obs_sf = stall_f; obs_sd = stall_d; obs_fd = flush_d; obs_fe = flush_e;
        obs_halted = halted; obs_fa = fwd_a_e; obs_fb = fwd_b_e;
        chk("stall_f", obs_sf, esf);
        chk("stall_d", obs_sd, esd);
        chk("flush_d", obs_fd, efd);
        chk("flush_e", obs_fe, efe);
        chk("halted", obs_halted, eh);
        chk("fwd_a_e", obs_fa, efa);
        chk("fwd_b_e", obs_fb, efb);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", perf_stall, m_pstall);
        chk("perf_flush", perf_flush, m_pflush);
`endif
        if (esf && !eh) m_pstall = m_pstall + 32'd1;
        if (efd) m_pflush = m_pflush + 32'd1;
        pw = pm;
        pm = pe;
        pe = efe ? '0 : ins_t'{rs1: rs1_d, rs2: rs2_d, rd: rd_d, rw: regwrite_d, ld: load_d};
    endtask

    task automatic cyc(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic rw, input logic ld, input logic pc,
                       input logic hl, input logic st);
        @(negedge clk);
        rs1_d = a; rs2_d = b; rd_d = d; regwrite_d = rw; load_d = ld;
        pcsrc_e = pc; dbg_halt = hl; dbg_step = st;
        #1;
        eval_and_check();
        @(posedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall_f"}, stall_f, 32'd0);
        chk({tag, "_stall_d"}, stall_d, 32'd0);
        chk({tag, "_flush_d"}, flush_d, 32'd0);
        chk({tag, "_flush_e"}, flush_e, 32'd0);
        chk({tag, "_halted"}, halted, 32'd0);
        chk({tag, "_fwd_a"}, fwd_a_e, 32'd0);
        chk({tag, "_fwd_b"}, fwd_b_e, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_perf_stall"}, perf_stall, 32'd0);
        chk({tag, "_perf_flush"}, perf_flush, 32'd0);
`endif
    endtask

    initial begin
        int first;
        int cnt;
        logic hl_lvl;
        logic [1:0] exp_fb;

        // Reset with hostile inputs: every output must still read 0.
        rst = 1'b0;
        rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0; regwrite_d = 1'b0; load_d = 1'b0;
        pcsrc_e = 1'b1; dbg_halt = 1'b1; dbg_step = 1'b1;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        pcsrc_e = 1'b0; dbg_halt = 1'b0; dbg_step = 1'b0;
        rst = 1'b1;

        // ALU result forwarding from M, then from W.
        cyc(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fwd_a_from_m", obs_fa, 2'b10);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fwd_a_from_w", obs_fa, 2'b01);
        chk("fwd_b_unrelated", obs_fb, 2'b00);

        // Load-use: dependent held in decode for LAT stall cycles.
        cyc(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < LAT + 1; i++) begin
            cyc(5'd0, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_sf && obs_sd && obs_fe) cnt++;
        end
        chk("load_use_stall_cycles", cnt, LAT);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_fb = (LAT == 1) ? 2'b01 : 2'b00;
        chk("load_use_fwd_b", obs_fb, exp_fb);

        // Taken branch beats a simultaneous load-use hazard.
        cyc(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br_over_lu_flush_d", obs_fd, 1'b1);
        chk("br_over_lu_flush_e", obs_fe, 1'b1);
        chk("br_over_lu_stall_f", obs_sf, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_stays_run", obs_sf, 1'b0);

        // x0 destination: no forwarding, no load-use stall.
        cyc(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0_no_stall", obs_sf, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0_no_fwd", obs_fa, 2'b00);

        // Debug halt latency.
        first = -1;
        for (int i = 0; i < 12; i++) begin
            cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_halted && first < 0) first = i;
        end
        chk("halt_latency", first, DRN + 1);

        // Single step: one released cycle, then re-drain to halted.
        cyc(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < DRN + 2; i++) begin
            cyc(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (!obs_sf) cnt++;
        end
        chk("step_release_cycles", cnt, 1);
        chk("step_rehalted", obs_halted, 1'b1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_stall_f", obs_sf, 1'b0);
        chk("resume_halted", obs_halted, 1'b0);
        chk("resume_flush_e", obs_fe, 1'b0);

        // Asynchronous reset in the middle of a load-use stall.
        cyc(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        eval_and_check();
        #1 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_stall_f", obs_sf, 1'b0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_fwd_a", obs_fa, 2'b00);

        // Random traffic against the model.
        hl_lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(19) == 0) hl_lvl = ~hl_lvl;
            cyc(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(7) == 0), hl_lvl, 1'($urandom_range(5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
